pattern_session_arbiter: RTL and testbench

PATTERN_SESSION_ARBITER -- requirements
Module: pattern_session_arbiter

---
 rtl/pattern_session_arbiter_pkg.sv | 24 ++
 rtl/pattern_session_arbiter_if.sv | 33 +++
 rtl/pattern_window_engine.sv | 50 +++++
 rtl/pattern_session_arbiter.sv | 119 +++++++++++
 tb/tb_pattern_session_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_session_arbiter_pkg.sv
// Shared definitions for the pattern session arbiter.
// Holds the FSM state encoding, the START/MARK nibbles, the result and
// channel-index widths, and a one-hot helper used to drive the grant vector.
package pattern_session_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ARMED,
        ST_COUNT,
        ST_DONE
    } state_t;

    localparam logic [3:0]  START_PAT = 4'b1001;
    localparam logic [3:0]  MARK_PAT  = 4'b0110;
    localparam int unsigned RES_W     = 7;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned NUM_CH    = 4;

    function automatic logic [NUM_CH-1:0] onehot(input logic [ID_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/pattern_session_arbiter_if.sv
// Request/grant/result bundle of the pattern session arbiter.
//   req     : per-requester session request (level)
//   bit_in  : per-requester serial data, one bit per clk
//   gnt     : one-hot grant, zero when idle
//   busy    : arbiter is not idle
//   done    : single-cycle session completion pulse
//   done_id : channel that completed (held after done)
//   result  : marker count of the completed session (held after done)
//   timeout : pulse with done when the session ran out of cycles
// master = requester side, slave = arbiter side.
interface pattern_session_arbiter_if;
    import pattern_session_arbiter_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] bit_in;
    logic [NUM_CH-1:0] gnt;
    logic              busy;
    logic              done;
    logic [ID_W-1:0]   done_id;
    logic [RES_W-1:0]  result;
    logic              timeout;

    modport master (
        output req, bit_in,
        input  gnt, busy, done, done_id, result, timeout
    );

    modport slave (
        input  req, bit_in,
        output gnt, busy, done, done_id, result, timeout
    );

endinterface

// File: rtl/pattern_window_engine.sv
// Serial pattern window for the granted channel.
// Keeps the last three received bits; the detection window is those three
// bits plus the bit arriving this cycle, so a pattern is recognised in the
// cycle its last bit is presented.
//   clk, reset : clock, async active-low reset
//   clear      : wipe history and marker count (session start)
//   armed      : waiting for START; a hit restarts the history
//   counting   : counting MARKs until the closing START
//   bit_in     : serial bit of the granted channel
//   start_hit  : window equals START this cycle
//   mark_cnt   : saturating marker count of the session
module pattern_window_engine
    import pattern_session_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             armed,
    input  logic             counting,
    input  logic             bit_in,
    output logic             start_hit,
    output logic [RES_W-1:0] mark_cnt
);

    logic [2:0] sh_q;
    logic [3:0] window;
    logic       mark_hit;

    assign window    = {sh_q, bit_in};
    assign start_hit = (window == START_PAT);
    assign mark_hit  = (window == MARK_PAT);

    // NOTE: state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q     <= '0;
            mark_cnt <= '0;
        end else if (clear) begin
            sh_q     <= '0;
            mark_cnt <= '0;
        end else if (armed || counting) begin
            // The opening START must not lend bits to the first MARK.
            sh_q <= (armed && start_hit) ? 3'b000 : window[2:0];
            if (counting && mark_hit && !start_hit && mark_cnt != '1) begin
                mark_cnt <= mark_cnt + RES_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_session_arbiter.sv
// Round-robin session arbiter with serial pattern counting.
// One requester at a time is granted a session: it sends START, then any
// number of MARKs, then START again; the number of MARKs is reported with
// a one-cycle done pulse. Sessions end early on timeout, and are dropped
// without a result if the granted requester withdraws its request.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of pattern_session_arbiter_if (req/bit_in in;
//           gnt/busy/done/done_id/result/timeout out)
module pattern_session_arbiter
    import pattern_session_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned N_CH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    pattern_session_arbiter_if.slave    bus
);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  sel_q, last_q, pick;
    logic [ID_W-1:0]  done_id_q;
    logic [RES_W-1:0] result_q, mark_cnt;
    logic [15:0]      cyc_q;
    logic             to_q, to_d;
    logic             req_sel, bit_sel, start_hit, cyc_hit, in_window, abort;

    assign req_sel   = bus.req[sel_q];
    assign bit_sel   = bus.bit_in[sel_q];
    assign in_window = (state_q == ST_ARMED) || (state_q == ST_COUNT);
    assign cyc_hit   = (cyc_q + 16'd1) == 16'(TIMEOUT);
    assign abort     = (state_q == ST_GRANT || in_window) && !req_sel;

    // Round-robin: walk from the farthest candidate to the nearest so the
    // first requester after last_q is the one left in pick.
    always_comb begin
        pick = last_q;
        for (int k = int'(N_CH); k >= 1; k--) begin
            if (bus.req[last_q + ID_W'(k)]) pick = last_q + ID_W'(k);
        end
    end

    // NOTE: defaults first, so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        to_d    = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (|bus.req) state_d = ST_GRANT;
            ST_GRANT: state_d = req_sel ? ST_ARMED : ST_IDLE;
            ST_ARMED: begin
                if (!req_sel) begin
                    state_d = ST_IDLE;
                end else if (cyc_hit) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end else if (start_hit) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // A closing START in the last allowed cycle is a clean end.
                if (!req_sel) begin
                    state_d = ST_IDLE;
                end else if (start_hit) begin
                    state_d = ST_DONE;
                end else if (cyc_hit) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            last_q    <= ID_W'(NUM_CH - 1);
            cyc_q     <= '0;
            to_q      <= 1'b0;
            result_q  <= '0;
            done_id_q <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            if (state_q == ST_IDLE) sel_q <= pick;
            if (state_q == ST_GRANT) cyc_q <= '0;
            else if (in_window)      cyc_q <= cyc_q + 16'd1;
            if (state_q == ST_DONE) begin
                result_q  <= mark_cnt;
                done_id_q <= sel_q;
            end
            if (state_q == ST_DONE || abort) last_q <= sel_q;
        end
    end

    pattern_window_engine u_window (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == ST_GRANT),
        .armed     (state_q == ST_ARMED),
        .counting  (state_q == ST_COUNT),
        .bit_in    (bit_sel),
        .start_hit (start_hit),
        .mark_cnt  (mark_cnt)
    );

    // Live values during DONE, registered copies held afterwards.
    assign bus.gnt     = (state_q == ST_IDLE) ? '0 : onehot(sel_q);
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.done_id = bus.done ? sel_q : done_id_q;
    assign bus.result  = bus.done ? mark_cnt : result_q;
    assign bus.timeout = to_q;

endmodule

// File: tb/tb_pattern_session_arbiter.sv
// Self-checking bench for pattern_session_arbiter.
// A driver plays sessions (directed and random) and pushes the expected
// completion of each into a queue; a monitor pops and compares whenever
// done is seen, and checks that result/done_id hold in between.
module tb_pattern_session_arbiter;
    import pattern_session_arbiter_pkg::*;

    localparam int TMO      = 1000;
    localparam int EV_NONE  = 0;
    localparam int EV_DROP  = 1;
    localparam int EV_RESET = 2;

    typedef struct {
        int     id;
        int     res;
        int     to;
        longint cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    pattern_session_arbiter_if bus ();

    pattern_session_arbiter #(.TIMEOUT(TMO), .N_CH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc_cnt  = 0;
    exp_t   exp_q[$];
    int     exp_res    = 0;
    int     exp_id     = 0;
    int     model_last = 3;
    int     lat_exp    = 1;
    bit     stim[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input longint act, input longint want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int rr_model(input logic [3:0] mask);
        logic [1:0] idx;
        for (int i = 1; i <= 4; i++) begin
            idx = 2'(model_last + i);
            if (mask[idx]) return int'(idx);
        end
        return 0;
    endfunction

    // Plays stim[] as the granted channel's bits, first bit in the first
    // armed cycle. Reports where the session ends and how.
    function automatic void model_session(input int stop_at, output bit ab,
                                          output int n, output int res, output int to);
        bit seg[$];
        int cnt;
        bit counting;
        int w;
        int lo;
        cnt = 0; counting = 0;
        ab = 0; n = 0; res = 0; to = 0;
        for (int k = 0; k < stim.size(); k++) begin
            if (k == stop_at) begin
                ab = 1; n = k;
                return;
            end
            seg.push_back(stim[k]);
            w  = 0;
            lo = (seg.size() > 4) ? seg.size() - 4 : 0;
            for (int j = lo; j < seg.size(); j++) w = w * 2 + int'(seg[j]);
            if (!counting) begin
                if (k + 1 == TMO) begin
                    n = k + 1; to = 1;
                    return;
                end
                if (w == 9) begin
                    counting = 1;
                    seg.delete();
                end
            end else begin
                if (w == 9) begin
                    n = k + 1; res = cnt;
                    return;
                end
                if (w == 6 && cnt < 127) cnt++;
                if (k + 1 == TMO) begin
                    n = k + 1; res = cnt; to = 1;
                    return;
                end
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic add(input logic [31:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) stim.push_back(v[i]);
    endtask

    task automatic pad(input bit rnd);
        while (stim.size() < TMO) stim.push_back(rnd ? 1'($urandom) : 1'b0);
    endtask

    task automatic noise(input int ch, input bit keep);
        logic [3:0] r;
        r       = 4'($urandom);
        r[ch]   = keep;
        bus.req = r;
        bus.bit_in = 4'($urandom);
    endtask

    task automatic check_reset_outputs();
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_done_id", bus.done_id, 0);
        check("rst_timeout", bus.timeout, 0);
    endtask

    // One session with stim[] as the granted channel's data. Entered on a
    // negedge; returns on the negedge of DONE, of the first idle cycle
    // after an abort, or of reset release.
    task automatic run_session(input logic [3:0] mask, input int ev_at, input int ev_kind);
        int   ch, n, res, to, lat;
        bit   ab;
        exp_t e;
        ch = rr_model(mask);
        model_session(ev_kind == EV_NONE ? -1 : ev_at, ab, n, res, to);
        bus.req = mask;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.gnt == 4'b0 && lat < 6);
        check("grant", bus.gnt, 1 << ch);
        check("grant_latency", lat, lat_exp);
        check("grant_busy", bus.busy, 1);
        noise(ch, 1'b1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            noise(ch, 1'b1);
            bus.bit_in[ch] = stim[k];
            if (!ab && k == n - 1) begin
                e.id = ch; e.res = res; e.to = to; e.cyc = cyc_cnt + 1;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        if (!ab) begin
            model_last = ch;
            lat_exp    = 2;
        end else if (ev_kind == EV_DROP) begin
            noise(ch, 1'b0);
            @(negedge clk);
            check("abort_busy", bus.busy, 0);
            check("abort_gnt", bus.gnt, 0);
            model_last = ch;
            lat_exp    = 1;
        end else begin
            reset = 1'b0;
            #1;
            check_reset_outputs();
            model_last = 3;
            exp_res    = 0;
            exp_id     = 0;
            lat_exp    = 1;
            @(negedge clk);
            reset = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_id", bus.done_id, e.id);
                    check("result", bus.result, e.res);
                    check("timeout", bus.timeout, e.to);
                    check("done_cycle", cyc_cnt, e.cyc);
                    check("done_gnt", bus.gnt, 1 << e.id);
                    exp_res = e.res;
                    exp_id  = e.id;
                end
            end else begin
                check("result_hold", bus.result, exp_res);
                check("done_id_hold", bus.done_id, exp_id);
                check("timeout_quiet", bus.timeout, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int kind, at, r;
        reset      = 1'b0;
        bus.req    = '0;
        bus.bit_in = '0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // All requesting, START then START: grants rotate 0,1,2,3,0.
        for (int s = 0; s < 5; s++) begin
            stim.delete(); add(32'h99, 8); pad(1);
            run_session(4'b1111, -1, EV_NONE);
        end

        // Channel 0 alone with the START/MARK/MARK/START stream.
        stim.delete(); add(32'h9669, 16); pad(0);
        run_session(4'b0001, -1, EV_NONE);

        // Channel 1: 135 overlapping MARKs, counter must saturate.
        stim.delete(); add(9, 4); add(0, 1);
        for (int i = 0; i < 135; i++) add(3'b110, 3);
        add(9, 4); pad(0);
        run_session(4'b0010, -1, EV_NONE);

        // Channel 2: silence until timeout while armed.
        stim.delete(); pad(0);
        run_session(4'b0100, -1, EV_NONE);

        // Channel 3: timeout while counting.
        stim.delete(); add(9, 4); add(0, 1);
        while (stim.size() < TMO) add(3'b110, 3);
        run_session(4'b1000, -1, EV_NONE);

        // Channel 3 completes with five MARKs, then aborts mid-count.
        stim.delete(); add(9, 4); add(0, 1);
        for (int i = 0; i < 5; i++) add(3'b110, 3);
        add(9, 4); pad(0);
        run_session(4'b1000, -1, EV_NONE);
        stim.delete(); add(9, 4); add(6, 4); pad(0);
        run_session(4'b1000, 10, EV_DROP);
        stim.delete(); add(32'h99, 8); pad(1);
        run_session(4'b1111, -1, EV_NONE);

        // Reset during COUNT, then the next grant restarts at channel 0.
        stim.delete(); add(9, 4); add(6, 4); pad(0);
        run_session(4'b0010, 10, EV_RESET);
        stim.delete(); add(32'h99, 8); pad(1);
        run_session(4'b1111, -1, EV_NONE);

        // Random sessions built from pattern fragments.
        for (int s = 0; s < 40; s++) begin
            stim.delete();
            while (stim.size() < 48) begin
                case ($urandom_range(0, 3))
                    0:       add(9, 4);
                    1:       add(6, 4);
                    2:       add(3'b011, 3);
                    default: add(32'($urandom), 4);
                endcase
            end
            pad(1);
            kind = EV_NONE;
            at   = -1;
            r    = $urandom_range(0, 9);
            if (r < 3) begin
                kind = EV_DROP;
                at   = $urandom_range(0, 30);
            end else if (r == 3) begin
                kind = EV_RESET;
                at   = $urandom_range(0, 30);
            end
            run_session(4'($urandom_range(1, 15)), at, kind);
        end

        bus.req = '0;
        repeat (4) @(negedge clk);
        check("pending_expect", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
